// File: rtl/ext_pkg.sv
// Shared types for the pipelined immediate extender (ext_pipe / ext_core).
// Optional skid buffer in ext_pipe is enabled with the EXT_SKID_EN macro.
package ext_pkg;

    typedef enum logic [1:0] {
        EXT_SIGN   = 2'b00,
        EXT_ZERO   = 2'b01,
        EXT_UPPER  = 2'b10,
        EXT_BRANCH = 2'b11
    } ext_mode_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_ONE   = 2'b01,
        S_TWO   = 2'b10
    } occ_t;

endpackage

// File: rtl/ext_core.sv
// Combinational immediate extender: widens an IN_W-bit immediate to OUT_W bits
// in sign, zero, upper-load or branch-offset mode.
module ext_core
    import ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  imm,
    input  ext_mode_t        mode,
    output logic [OUT_W-1:0] value
);

    localparam int E = OUT_W - IN_W;

    logic [OUT_W-1:0] sign_v;

    always_comb begin
        sign_v = {{E{imm[IN_W-1]}}, imm};
        case (mode)
            EXT_SIGN:   value = sign_v;
            EXT_ZERO:   value = {{E{1'b0}}, imm};
            EXT_UPPER:  value = {imm, {E{1'b0}}};
            EXT_BRANCH: value = {sign_v[OUT_W-3:0], 2'b00};
            default:    value = sign_v;
        endcase
    end

endmodule

// File: rtl/ext_pipe.sv
// Pipelined immediate extender with valid/ready handshake on both sides.
// Define EXT_SKID_EN for a two-entry skid buffer with registered in_ready.
module ext_pipe
    import ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  ext_mode_t        in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_neg
);

    if (IN_W < 1) begin : g_bad_in_w
        $error("ext_pipe: IN_W must be at least 1");
    end
    if (OUT_W < IN_W + 2) begin : g_bad_out_w
        $error("ext_pipe: OUT_W must be at least IN_W + 2");
    end

    logic [OUT_W-1:0] ext_value;
    logic             accept;
    logic             xfer;

    ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .imm   (in_imm),
        .mode  (in_mode),
        .value (ext_value)
    );

    assign accept  = in_valid && in_ready;
    assign xfer    = out_valid && out_ready;
    assign out_neg = out_data[OUT_W-1];

`ifdef EXT_SKID_EN
    occ_t             state;
    logic [OUT_W-1:0] skid_data;
    logic [TAG_W-1:0] skid_tag;

    // out_data/out_tag are the head entry; skid holds the second beat in S_TWO.
    // in_ready resets low and rises on the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_EMPTY;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
            skid_data <= '0;
            skid_tag  <= '0;
        end else begin
            case (state)
                S_EMPTY: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        out_data  <= ext_value;
                        out_tag   <= in_tag;
                        out_valid <= 1'b1;
                        state     <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (accept && xfer) begin
                        out_data <= ext_value;
                        out_tag  <= in_tag;
                    end else if (accept) begin
                        skid_data <= ext_value;
                        skid_tag  <= in_tag;
                        in_ready  <= 1'b0;
                        state     <= S_TWO;
                    end else if (xfer) begin
                        out_valid <= 1'b0;
                        state     <= S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (xfer) begin
                        out_data <= skid_data;
                        out_tag  <= skid_tag;
                        in_ready <= 1'b1;
                        state    <= S_ONE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= S_EMPTY;
                end
            endcase
        end
    end
`else
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
        end else if (accept) begin
            out_data  <= ext_value;
            out_tag   <= in_tag;
            out_valid <= 1'b1;
        end else if (xfer) begin
            out_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_ext_pipe.sv
// Scoreboard bench for ext_pipe: directed vectors, back-pressure, throughput,
// mid-stall reset and random traffic on three width configurations.
module tb_ext_pipe;
    import ext_pkg::*;

    localparam int IW_A [3] = '{16, 12, 8};
    localparam int OW_A [3] = '{32, 32, 16};
`ifdef EXT_SKID_EN
    localparam int STALL_ACC = 2;
`else
    localparam int STALL_ACC = 1;
`endif

    typedef struct {
        logic [31:0] d;
        logic [4:0]  t;
        logic        n;
        int unsigned cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [31:0] in_imm    [3];
    logic [1:0]  in_mode   [3];
    logic [4:0]  in_tag    [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [31:0] out_data  [3];
    logic [4:0]  out_tag   [3];
    logic        out_neg   [3];

    exp_t        q [3][$];
    logic        acc     [3];
    logic        stalled [3];
    logic [31:0] hold_d  [3];
    logic [4:0]  hold_t  [3];
    logic        lat_chk = 1'b0;
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;

    logic [31:0] v_imm  [6] = '{32'h8001, 32'h7FFF, 32'h8001, 32'h1234, 32'hFFFF, 32'h4000};
    logic [1:0]  v_mode [6] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    logic [31:0] v_exp  [6] = '{32'hFFFF8001, 32'h00007FFF, 32'h00008001,
                                32'h12340000, 32'hFFFFFFFC, 32'h00010000};
    logic        v_neg  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g
        localparam int IW = IW_A[k];
        localparam int OW = OW_A[k];
        logic [OW-1:0] od;

        ext_pipe #(
            .IN_W  (IW),
            .OUT_W (OW),
            .TAG_W (5)
        ) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[k]),
            .in_ready  (in_ready[k]),
            .in_imm    (in_imm[k][IW-1:0]),
            .in_mode   (ext_mode_t'(in_mode[k])),
            .in_tag    (in_tag[k]),
            .out_valid (out_valid[k]),
            .out_ready (out_ready[k]),
            .out_data  (od),
            .out_tag   (out_tag[k]),
            .out_neg   (out_neg[k])
        );

        assign out_data[k] = 32'(od);
    end

    // Bit-by-bit reference: each output bit picks its source bit directly.
    function automatic logic [31:0] ref_ext(input logic [31:0] imm, input logic [1:0] m,
                                            input int iw, input int ow);
        logic [31:0] r;
        int e;
        r = '0;
        e = ow - iw;
        for (int i = 0; i < ow; i++) begin
            case (m)
                2'd0:    r[i] = (i < iw) ? imm[i] : imm[iw-1];
                2'd1:    r[i] = (i < iw) ? imm[i] : 1'b0;
                2'd2:    r[i] = (i >= e) ? imm[i-e] : 1'b0;
                default: r[i] = (i < 2) ? 1'b0 : ((i - 2 < iw) ? imm[i-2] : imm[iw-1]);
            endcase
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // One cycle: sample at the falling edge, score transfers, then step past the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        for (int k = 0; k < 3; k++) begin
            acc[k] = 1'b0;
            if (rst_n) begin
                if (stalled[k]) begin
                    chk($sformatf("stable_data%0d", k), out_data[k], hold_d[k]);
                    chk($sformatf("stable_tag%0d", k), out_tag[k], hold_t[k]);
                end
                if (out_valid[k] && out_ready[k]) begin
                    chk($sformatf("expected_beat%0d", k), q[k].size() != 0, 1);
                    if (q[k].size() != 0) begin
                        e = q[k].pop_front();
                        chk($sformatf("data%0d", k), out_data[k], e.d);
                        chk($sformatf("tag%0d", k), out_tag[k], e.t);
                        chk($sformatf("neg%0d", k), out_neg[k], e.n);
                        if (lat_chk) chk($sformatf("latency%0d", k), cyc, e.cyc + 1);
                    end
                end
                stalled[k] = out_valid[k] && !out_ready[k];
                hold_d[k]  = out_data[k];
                hold_t[k]  = out_tag[k];
                if (in_valid[k] && in_ready[k]) begin
                    e.d   = ref_ext(in_imm[k], in_mode[k], IW_A[k], OW_A[k]);
                    e.t   = in_tag[k];
                    e.n   = e.d[OW_A[k]-1];
                    e.cyc = cyc;
                    q[k].push_back(e);
                    acc[k] = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load0(input logic [4:0] t);
        in_imm[0]  = $urandom;
        in_mode[0] = 2'($urandom_range(0, 3));
        in_tag[0]  = t;
    endtask

    task automatic send0(input logic [31:0] imm, input logic [1:0] m, input logic [4:0] t);
        int n;
        n = 0;
        in_valid[0] = 1'b1;
        in_imm[0]   = imm;
        in_mode[0]  = m;
        in_tag[0]   = t;
        do begin
            tick();
            n++;
        end while (!acc[0] && n < 50);
        chk("send_accept", acc[0], 1);
        in_valid[0] = 1'b0;
    endtask

    initial begin
        int idx;
        int n;
        for (int k = 0; k < 3; k++) begin
            in_valid[k] = 1'b0; in_imm[k] = '0; in_mode[k] = '0; in_tag[k] = '0;
            out_ready[k] = 1'b0; acc[k] = 1'b0; stalled[k] = 1'b0;
            hold_d[k] = '0; hold_t[k] = '0;
        end

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid[0], 0);
        chk("rst_out_data", out_data[0], 0);
        chk("rst_out_tag", out_tag[0], 0);
        chk("rst_out_neg", out_neg[0], 0);
        rst_n = 1'b1;
        tick();
        chk("in_ready_after_init", in_ready[0], 1);

        out_ready[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send0(v_imm[i], v_mode[i], 5'(i + 1));
            chk($sformatf("vec%0d_valid", i), out_valid[0], 1);
            chk($sformatf("vec%0d_data", i), out_data[0], v_exp[i]);
            chk($sformatf("vec%0d_neg", i), out_neg[0], v_neg[i]);
        end
        tick();

        out_ready[0] = 1'b0;
        idx = 1;
        load0(5'(idx));
        in_valid[0] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (acc[0]) begin
                idx++;
                load0(5'(idx));
            end
        end
        chk("stall_accepts", idx - 1, STALL_ACC);
        chk("stall_in_ready", in_ready[0], 0);
        out_ready[0] = 1'b1;
        n = 0;
        while (idx <= 6 && n < 50) begin
            tick();
            n++;
            if (acc[0]) begin
                idx++;
                if (idx <= 6) load0(5'(idx));
            end
        end
        in_valid[0] = 1'b0;
        chk("stream_complete", idx, 7);
        repeat (4) tick();
        chk("bp_drained", q[0].size(), 0);

        lat_chk = 1'b1;
        for (int i = 0; i < 8; i++) begin
            load0(5'(i + 10));
            in_valid[0] = 1'b1;
            tick();
            chk("tput_accept", acc[0], 1);
        end
        in_valid[0] = 1'b0;
        repeat (3) tick();
        lat_chk = 1'b0;
        chk("tput_drained", q[0].size(), 0);

        out_ready[0] = 1'b0;
        load0(5'd20);
        in_valid[0] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (acc[0]) load0(5'd21);
        end
        in_valid[0] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid[0], 0);
        chk("midrst_out_data", out_data[0], 0);
        chk("midrst_out_tag", out_tag[0], 0);
        chk("midrst_out_neg", out_neg[0], 0);
        for (int k = 0; k < 3; k++) begin
            q[k].delete();
            stalled[k] = 1'b0;
        end
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_in_ready", in_ready[0], 1);
        out_ready[0] = 1'b1;
        repeat (4) tick();
        chk("midrst_no_stale", out_valid[0], 0);

        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < 3; k++) begin
                if (!in_valid[k] || acc[k]) begin
                    in_valid[k] = ($urandom_range(0, 3) != 0);
                    in_imm[k]   = $urandom;
                    in_mode[k]  = 2'($urandom_range(0, 3));
                    in_tag[k]   = 5'($urandom_range(0, 31));
                end
                out_ready[k] = ($urandom_range(0, 3) != 0);
            end
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b1;
        end
        repeat (5) tick();
        for (int k = 0; k < 3; k++) chk($sformatf("rand_drained%0d", k), q[k].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
